// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter width for a given operand width; must hold WIDTH+1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A,
// then arithmetic right shift of the {A, Q, Q_1} chain.
module booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH+1:0] a_i,
    input  logic [WIDTH:0]   q_i,
    input  logic             q_1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH+1:0] a_o,
    output logic [WIDTH:0]   q_o,
    output logic             q_1_o
);

    logic [WIDTH+1:0] m_x;
    logic [WIDTH+1:0] sum;

    // A carries one guard bit over M so that -M of the most-negative M fits.
    assign m_x = {m_i[WIDTH], m_i};

    always_comb begin
        case ({q_i[0], q_1_i})
            2'b01:   sum = a_i + m_x;
            2'b10:   sum = a_i - m_x;
            default: sum = a_i;
        endcase
    end

    assign a_o   = {sum[WIDTH+1], sum[WIDTH+1:1]};
    assign q_o   = {sum[0], q_i[WIDTH:1]};
    assign q_1_o = q_i[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: WIDTH+1 steps per product for both
// signed and unsigned operands; the result is latched on the final step.
module booth_mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mult_hi,
    output logic [WIDTH-1:0] mult_lo
);

    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] STEPS = CNT_W'(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH+1:0] a_q, a_d;
    logic [WIDTH:0]   q_q, q_d;
    logic [WIDTH:0]   m_q, m_d;
    logic             q1_q, q1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH+1:0] step_a;
    logic [WIDTH:0]   step_q;
    logic             step_q1;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   q_ext;

    // Zero-extending unsigned operands lets the signed Booth datapath serve both modes.
    assign m_ext = signed_mode ? {multiplicand[WIDTH-1], multiplicand} : {1'b0, multiplicand};
    assign q_ext = signed_mode ? {multiplier[WIDTH-1], multiplier} : {1'b0, multiplier};

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a_i   (a_q),
        .q_i   (q_q),
        .q_1_i (q1_q),
        .m_i   (m_q),
        .a_o   (step_a),
        .q_o   (step_q),
        .q_1_o (step_q1)
    );

    always_comb begin
        // NOTE: every target gets its hold value first so no path infers a latch.
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = '0;
                    q_d     = q_ext;
                    m_d     = m_ext;
                    q1_d    = 1'b0;
                    cnt_d   = STEPS;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = step_a;
                q_d   = step_q;
                q1_d  = step_q1;
                cnt_d = cnt_q - LAST;
                if (cnt_q == LAST) begin
                    // Low 2*WIDTH bits of the {A, Q} product chain.
                    hi_d    = {step_a[WIDTH-2:0], step_q[WIDTH]};
                    lo_d    = step_q[WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop update from pre-edge values.
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign mult_hi = hi_q;
    assign mult_lo = lo_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: 32-bit and 8-bit instances, vector
// tables, multi-cycle corner sequences and random operands against a product model.
module tb_booth_mult_seq;

    typedef struct {
        logic        sm;
        logic [31:0] m;
        logic [31:0] q;
        logic [63:0] prod;
    } vec32_t;

    typedef struct {
        logic        sm;
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] prod;
    } vec8_t;

    logic        clk;
    logic        reset_n;
    logic        start, signed_mode;
    logic [31:0] mcand, mplier;
    logic        busy, done;
    logic [31:0] hi32, lo32;

    logic        start8, sm8;
    logic [7:0]  mc8, mp8;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] prev32 = '0;
    logic [15:0] prev8  = '0;

    vec32_t vec32[8];
    vec8_t  vec8[7];

    booth_mult_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .busy         (busy),
        .done         (done),
        .mult_hi      (hi32),
        .mult_lo      (lo32)
    );

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start8),
        .signed_mode  (sm8),
        .multiplicand (mc8),
        .multiplier   (mp8),
        .busy         (busy8),
        .done         (done8),
        .mult_hi      (hi8),
        .mult_lo      (lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model32(input logic sm, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ua, ub;
        if (sm) return 64'(longint'($signed(a)) * longint'($signed(b)));
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    function automatic logic [15:0] model8(input logic sm, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] ua, ub;
        if (sm) return 16'(int'($signed(a)) * int'($signed(b)));
        ua = {8'd0, a};
        ub = {8'd0, b};
        return ua * ub;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op32(input string name, input logic sm, input logic [31:0] m,
                        input logic [31:0] q, input logic [63:0] exp);
        int lat;
        bit seen;
        signed_mode = sm;
        mcand       = m;
        mplier      = q;
        start       = 1'b1;
        tick();
        start = 1'b0;
        check({name, " busy"}, 64'(busy), 64'd1);
        check({name, " held"}, {hi32, lo32}, prev32);
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 200 && !seen; k++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check({name, " latency"}, 64'(lat), 64'd33);
        check({name, " product"}, {hi32, lo32}, exp);
        tick();
        check({name, " idle"}, {62'd0, done, busy}, 64'd0);
        check({name, " kept"}, {hi32, lo32}, exp);
        prev32 = exp;
    endtask

    task automatic op8(input string name, input logic sm, input logic [7:0] m,
                       input logic [7:0] q, input logic [15:0] exp);
        int lat;
        bit seen;
        sm8    = sm;
        mc8    = m;
        mp8    = q;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check({name, " busy"}, 64'(busy8), 64'd1);
        check({name, " held"}, 64'({hi8, lo8}), 64'(prev8));
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 50 && !seen; k++) begin
            tick();
            if (done8) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check({name, " latency"}, 64'(lat), 64'd9);
        check({name, " product"}, 64'({hi8, lo8}), 64'(exp));
        tick();
        check({name, " idle"}, {62'd0, done8, busy8}, 64'd0);
        prev8 = exp;
    endtask

    initial begin
        int          dones, first, second;
        logic [31:0] ra, rb;
        logic [7:0]  ra8, rb8;
        logic        rs;

        vec32[0] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
        vec32[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vec32[2] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vec32[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vec32[4] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
        vec32[5] = '{1'b1, 32'h0000_0001, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000};
        vec32[6] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        vec32[7] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};

        vec8[0] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        vec8[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vec8[2] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vec8[3] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vec8[4] = '{1'b0, 8'h80, 8'h80, 16'h4000};
        vec8[5] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
        vec8[6] = '{1'b0, 8'h00, 8'hA5, 16'h0000};

        reset_n     = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        mcand       = '0;
        mplier      = '0;
        start8      = 1'b0;
        sm8         = 1'b0;
        mc8         = '0;
        mp8         = '0;

        #2 reset_n = 1'b0;
        #1;
        check("reset32", {hi32, lo32}, 64'd0);
        check("reset32 flags", {62'd0, done, busy}, 64'd0);
        check("reset8", {46'd0, hi8, lo8, done8, busy8}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // First start is accepted on the very first edge after reset release.
        for (int i = 0; i < 8; i++)
            op32($sformatf("vec32[%0d]", i), vec32[i].sm, vec32[i].m, vec32[i].q, vec32[i].prod);

        // Start pulse and operand changes mid-run must not disturb the running op.
        signed_mode = 1'b1;
        mcand       = 32'd5;
        mplier      = 32'd6;
        start       = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        first = 0;
        for (int k = 1; k <= 80; k++) begin
            if (k == 10) begin
                start       = 1'b1;
                signed_mode = 1'b0;
                mcand       = 32'hDEAD_BEEF;
                mplier      = 32'h1234_5678;
            end
            if (k == 11) start = 1'b0;
            tick();
            if (done) begin
                dones++;
                if (first == 0) first = k;
            end
        end
        check("midrun latency", 64'(first), 64'd33);
        check("midrun done count", 64'(dones), 64'd1);
        check("midrun product", {hi32, lo32}, 64'd30);
        prev32 = 64'd30;

        // Reset in the middle of a run abandons it and clears the outputs.
        signed_mode = 1'b0;
        mcand       = 32'd100;
        mplier      = 32'd200;
        start       = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        #2 reset_n = 1'b0;
        #1;
        check("midrun reset product", {hi32, lo32}, 64'd0);
        check("midrun reset flags", {62'd0, done, busy}, 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        prev32  = '0;
        op32("after reset", 1'b0, 32'd1234, 32'd5678, 64'd7006652);

        // Start held high: products complete every WIDTH+3 cycles, nothing queued.
        signed_mode = 1'b1;
        mcand       = 32'hFFFF_FF00;
        mplier      = 32'h0001_0001;
        start       = 1'b1;
        dones       = 0;
        first       = 0;
        second      = 0;
        for (int k = 0; k <= 72; k++) begin
            tick();
            if (k == 69) start = 1'b0;
            if (done) begin
                dones++;
                if (first == 0) first = k;
                else if (second == 0) second = k;
            end
        end
        check("throughput first", 64'(first), 64'd33);
        check("throughput spacing", 64'(second - first), 64'd35);
        check("throughput count", 64'(dones), 64'd2);
        check("throughput product", {hi32, lo32}, model32(1'b1, 32'hFFFF_FF00, 32'h0001_0001));
        repeat (40) tick();
        check("throughput drained", 64'(busy), 64'd0);
        prev32 = model32(1'b1, 32'hFFFF_FF00, 32'h0001_0001);

        for (int i = 0; i < 20; i++) begin
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'h8000_0000;
                1:       rb = 32'h7FFF_FFFF;
                default: rb = $urandom;
            endcase
            op32($sformatf("rand32[%0d] sm=%0d %h*%h", i, rs, ra, rb), rs, ra, rb, model32(rs, ra, rb));
        end

        for (int i = 0; i < 7; i++)
            op8($sformatf("vec8[%0d]", i), vec8[i].sm, vec8[i].m, vec8[i].q, vec8[i].prod);

        for (int i = 0; i < 12; i++) begin
            rs  = 1'($urandom_range(0, 1));
            ra8 = 8'($urandom);
            rb8 = 8'($urandom);
            op8($sformatf("rand8[%0d] sm=%0d %h*%h", i, rs, ra8, rb8), rs, ra8, rb8, model8(rs, ra8, rb8));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; legal range 4..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 signed_mode  input  1  1 = signed (MULT), 0 = unsigned (MULTU); captured with operands.
REQ-006 multiplicand  input  WIDTH  operand M; captured at accepted start.
REQ-007 multiplier  input  WIDTH  operand Q; captured at accepted start.
REQ-008 busy  output  1  high in RUN and DONE states.
REQ-009 done  output  1  single-cycle completion pulse.
REQ-010 mult_hi  output  WIDTH  upper half of 2*WIDTH product.
REQ-011 mult_lo  output  WIDTH  lower half of 2*WIDTH product.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 IDLE with start=1 at edge N: operands sign-extended (signed_mode=1) or zero-extended (signed_mode=0) to WIDTH+1 bits; A cleared; Q_1 cleared; step counter set to WIDTH+1; go to RUN.
REQ-014 IDLE with start=0: remain in IDLE; no register other than the FSM changes.
REQ-015 Each RUN cycle SHALL perform one radix-2 Booth step on {Q[0],Q_1}: 01 -> A+M, 10 -> A-M, 00/11 -> no add.
REQ-015a After the add, each RUN cycle SHALL arithmetic-shift {A,Q,Q_1} right by one and decrement the counter.
REQ-016 Accumulator A SHALL be WIDTH+2 bits so that no intermediate overflows, including M = most-negative value.
REQ-017 Iteration count SHALL be WIDTH+1 for both modes, giving fixed latency independent of operand values and mode.
REQ-018 On the edge performing the final step (N+WIDTH+1), mult_hi/mult_lo SHALL load the low 2*WIDTH bits of the result; state goes to DONE.
REQ-019 done SHALL be 1 exactly in the cycle following edge N+WIDTH+1; DONE -> IDLE unconditionally on the next edge.
REQ-020 mult_hi/mult_lo SHALL hold their last result until the next completion; they are not cleared by start or by return to IDLE.
REQ-021 start while busy=1 SHALL be ignored; no queueing. Operand or mode changes during RUN SHALL have no effect.
REQ-022 Next start is accepted no earlier than the IDLE cycle after done; throughput is one product per WIDTH+3 cycles.
REQ-023 Unsigned results SHALL equal the full-precision unsigned product; signed results SHALL equal the two's-complement product.

Reset
REQ-024 reset_n=0 SHALL immediately force: IDLE, busy=0, done=0, mult_hi=0, mult_lo=0, A/Q/Q_1/counter=0.
REQ-025 Reset asserted mid-RUN SHALL abandon the operation; no done pulse is produced for it.
REQ-026 First start is accepted on the first rising edge after reset_n deasserts.

Structure
REQ-027 Shared package mult_pkg SHALL hold the FSM state type (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-027a The counter width constant, $clog2(WIDTH+2), SHALL also live in mult_pkg.
REQ-028 A combinational sub-module booth_step SHALL compute one add/sub+shift; it takes A, Q, Q_1 and M and returns the next A, Q, Q_1.

Verification (WIDTH=32 unless noted)
REQ-029 Signed 0x00000007 * 0xFFFFFFFD -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done exactly 33 cycles after the start edge.
REQ-030 Unsigned 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-030a Signed 0xFFFFFFFF * 0xFFFFFFFF -> hi=0x00000000, lo=0x00000001.
REQ-031 Signed 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-031a Unsigned 0x80000000 * 0x00000002 -> hi=0x00000001, lo=0x00000000.
REQ-032 Operation 1 is 5*6 signed; start pulsed and operands changed at cycle 10 of the run -> result hi=0, lo=30; no second done.
REQ-032a After the REQ-032 result, reset_n is pulsed low mid-run of a new op -> outputs 0, busy=0, no done; the next start works normally.
REQ-033 WIDTH=8 instance, signed 0x80*0x7F -> hi=0xC0, lo=0x80; unsigned 0xFF*0xFF -> hi=0xFE, lo=0x01; latency 9 cycles.
